conv_main_fsm: RTL and testbench
================================

// Module: conv_main_fsm
// PURPOSE
//  Main control FSM of the accelerator; consumes the register-bank outputs (IN_ADDR..OCH, START)
//  and returns conv_finish to it. Per output-channel group it walks input channels: load 3x3
//  weights, 1x1 weights, input map via DMA, runs the PE array, then stores the output group.
// PARAMETERS
//  PE_OCH  8   output channels per compute pass (weights/output lengths scale by this)
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous active-high reset
//  IN_ADDR        in   32  input map base (bytes)
//  W3_ADDR        in   32  3x3 weight base
//  W1_ADDR        in   32  1x1 weight base
//  OUT_ADDR       in   32  output map base
//  START          in   32  bit0 = start pulse; bits 31:1 ignored
//  MAPSIZE        in   32  map side; bits 15:0 used
//  ICH / OCH      in   32  input / output channel count
//  dma_req_valid  out  1   DMA request valid
//  dma_req_ready  in   1   DMA accepts request
//  dma_req_write  out  1   1 = store to memory, 0 = load
//  dma_req_sel    out  2   buffer: 0 W3, 1 W1, 2 IN, 3 OUT
//  dma_req_addr   out  32  byte address
//  dma_req_len    out  32  byte length
//  dma_done       in   1   one-cycle pulse: accepted transfer finished
//  comp_start     out  1   one-cycle pulse to PE array
//  comp_first     out  1   valid with comp_start: first ich (clear accumulators)
//  comp_och_num   out  8   valid output channels this group, 1..PE_OCH
//  comp_done      in   1   one-cycle pulse from PE array
//  busy           out  1   high while not IDLE
//  conv_finish    out  1   one-cycle pulse at end of layer
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, counters/pointers 0; applies mid-operation and drops
//   dma_req_valid at that edge; no in-flight transfer or compute tracked after reset.
//  States: IDLE, LD_W3, LD_W1, LD_IN, COMP, ST_OUT, FIN.
//  IDLE: START[0]=1 latches AREA=MAPSIZE[15:0]*MAPSIZE[15:0] (32b), ICH, OCH, pointers
//   w3p=W3_ADDR, w1p=W1_ADDR, inp=IN_ADDR, outp=OUT_ADDR, ich_cnt=0, och_base=0.
//   If ICH, OCH or AREA is 0 -> FIN, else -> LD_W3. START in any other state is ignored.
//  DMA states: dma_req_valid goes high the cycle the state is entered; request fields held
//   stable until valid&ready; valid then drops and the FSM waits for dma_done (done may come
//   the cycle after accept). Next state entered the cycle after dma_done.
//   LD_W3: addr w3p, len 9*PE_OCH, sel 0;  w3p += 9*PE_OCH on done      -> LD_W1
//   LD_W1: addr w1p, len PE_OCH,   sel 1;  w1p += PE_OCH on done        -> LD_IN
//   LD_IN: addr inp, len AREA,     sel 2;  inp += AREA on done          -> COMP
//   ST_OUT: write=1, addr outp, len AREA*PE_OCH, sel 3; outp += that on done
//  COMP: comp_start pulses on the entry cycle with comp_first=(ich_cnt==0); wait comp_done.
//   If ich_cnt<ICH-1: ich_cnt++ -> LD_W3; else ich_cnt=0 -> ST_OUT.
//  After ST_OUT: och_base += PE_OCH; if och_base<OCH: inp=IN_ADDR -> LD_W3; else -> FIN.
//  comp_och_num = min(PE_OCH, OCH-och_base); lengths always use full PE_OCH (padded weights).
//  FIN: conv_finish=1 for exactly one cycle -> IDLE. busy=0 only in IDLE.
//  dma_done outside a wait phase and comp_done outside COMP are ignored.
//  Pointer/length arithmetic is 32-bit unsigned, wraps mod 2^32.
// TESTING
//  1) MAPSIZE=4, ICH=2, OCH=8: req seq W3@W3_ADDR len72, W1 len8, IN len16, COMP(first=1),
//     W3@+72, W1@+8, IN@IN_ADDR+16, COMP(first=0), OUT write len128; one conv_finish.
//  2) OCH=10, ICH=1: two groups; comp_och_num 8 then 2; 2nd OUT addr OUT_ADDR+AREA*8; inp reset.
//  3) ICH=0 (or MAPSIZE=0): START -> conv_finish 2 cycles later, no dma_req_valid ever.
//  4) dma_req_ready low 5 cycles: valid and addr/len/sel stable, no advance until accept.
//  5) START and stray comp_done/dma_done pulses during LD_IN: ignored, sequence unchanged.
//  6) rst mid-COMP: next cycle IDLE, busy=0, outputs 0; new START restarts from base addrs.

Source files
------------

// File: rtl/conv_main_fsm_if.sv
// DMA request/completion and PE-array handshake between the main control FSM and the datapath.
interface conv_main_fsm_if;
    logic        dma_req_valid;
    logic        dma_req_ready;
    logic        dma_req_write;
    logic [1:0]  dma_req_sel;
    logic [31:0] dma_req_addr;
    logic [31:0] dma_req_len;
    logic        dma_done;
    logic        comp_start;
    logic        comp_first;
    logic [7:0]  comp_och_num;
    logic        comp_done;

    // Control FSM side
    modport master (
        output dma_req_valid, dma_req_write, dma_req_sel, dma_req_addr, dma_req_len,
        input  dma_req_ready, dma_done,
        output comp_start, comp_first, comp_och_num,
        input  comp_done
    );

    // DMA engine / PE array side
    modport slave (
        input  dma_req_valid, dma_req_write, dma_req_sel, dma_req_addr, dma_req_len,
        output dma_req_ready, dma_done,
        input  comp_start, comp_first, comp_och_num,
        output comp_done
    );
endinterface

// File: rtl/conv_main_fsm.sv
// Main convolution control FSM: per output-channel group, walks the input channels loading
// 3x3 weights, 1x1 weights and the input map, runs the PE array, then stores the output group.
module conv_main_fsm #(
    parameter int unsigned PE_OCH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     IN_ADDR,
    input  logic [31:0]     W3_ADDR,
    input  logic [31:0]     W1_ADDR,
    input  logic [31:0]     OUT_ADDR,
    input  logic [31:0]     START,
    input  logic [31:0]     MAPSIZE,
    input  logic [31:0]     ICH,
    input  logic [31:0]     OCH,
    conv_main_fsm_if.master bus,
    output logic            busy,
    output logic            conv_finish
);
    localparam int unsigned AW = 32;
    localparam int unsigned NW = 8;
    localparam logic [AW-1:0] W3_LEN  = AW'(9 * PE_OCH);
    localparam logic [AW-1:0] W1_LEN  = AW'(PE_OCH);
    localparam logic [AW-1:0] GRP_OCH = AW'(PE_OCH);
    localparam logic [NW-1:0] MAX_NUM = NW'(PE_OCH);
    localparam logic [1:0] SEL_W3  = 2'd0;
    localparam logic [1:0] SEL_W1  = 2'd1;
    localparam logic [1:0] SEL_IN  = 2'd2;
    localparam logic [1:0] SEL_OUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LD_W3  = 3'd1,
        S_LD_W1  = 3'd2,
        S_LD_IN  = 3'd3,
        S_COMP   = 3'd4,
        S_ST_OUT = 3'd5,
        S_FIN    = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   area_q, area_d, ich_q, ich_d, och_q, och_d;
    logic [AW-1:0]   w3p_q, w3p_d, w1p_q, w1p_d, inp_q, inp_d, outp_q, outp_d;
    logic [AW-1:0]   ich_cnt_q, ich_cnt_d, och_base_q, och_base_d;
    logic            req_valid_q, req_valid_d, req_write_q, req_write_d;
    logic [1:0]      req_sel_q, req_sel_d;
    logic [AW-1:0]   req_addr_q, req_addr_d, req_len_q, req_len_d;
    logic            comp_start_q, comp_start_d, comp_first_q, comp_first_d;
    logic [NW-1:0]   och_num_q, och_num_d;
    logic            busy_q, busy_d, finish_q, finish_d;

    logic [AW-1:0]   map_area;
    logic [AW-1:0]   out_len;
    logic [AW-1:0]   och_left;
    logic            xfer_done;
    logic            unused_bits;

    assign map_area    = AW'(MAPSIZE[15:0]) * AW'(MAPSIZE[15:0]);
    assign out_len     = area_q * GRP_OCH;
    assign unused_bits = ^{START[31:1], MAPSIZE[31:16]};

    // Next-state, pointer updates and next values of all registered outputs
    always_comb begin
        state_d      = state_q;
        area_d       = area_q;
        ich_d        = ich_q;
        och_d        = och_q;
        w3p_d        = w3p_q;
        w1p_d        = w1p_q;
        inp_d        = inp_q;
        outp_d       = outp_q;
        ich_cnt_d    = ich_cnt_q;
        och_base_d   = och_base_q;
        req_valid_d  = req_valid_q;
        req_write_d  = req_write_q;
        req_sel_d    = req_sel_q;
        req_addr_d   = req_addr_q;
        req_len_d    = req_len_q;
        comp_start_d = 1'b0;
        comp_first_d = 1'b0;
        och_num_d    = och_num_q;
        och_left     = '0;

        // A held request drops once accepted; completion only counts after that
        if (req_valid_q && bus.dma_req_ready) begin
            req_valid_d = 1'b0;
        end
        xfer_done = !req_valid_q && bus.dma_done;

        unique case (state_q)
            S_IDLE: begin
                if (START[0]) begin
                    area_d     = map_area;
                    ich_d      = ICH;
                    och_d      = OCH;
                    w3p_d      = W3_ADDR;
                    w1p_d      = W1_ADDR;
                    inp_d      = IN_ADDR;
                    outp_d     = OUT_ADDR;
                    ich_cnt_d  = '0;
                    och_base_d = '0;
                    state_d    = (ICH == '0 || OCH == '0 || map_area == '0) ? S_FIN : S_LD_W3;
                end
            end
            S_LD_W3: begin
                if (xfer_done) begin
                    w3p_d   = w3p_q + W3_LEN;
                    state_d = S_LD_W1;
                end
            end
            S_LD_W1: begin
                if (xfer_done) begin
                    w1p_d   = w1p_q + W1_LEN;
                    state_d = S_LD_IN;
                end
            end
            S_LD_IN: begin
                if (xfer_done) begin
                    inp_d   = inp_q + area_q;
                    state_d = S_COMP;
                end
            end
            S_COMP: begin
                if (bus.comp_done) begin
                    if (ich_cnt_q < ich_q - 32'd1) begin
                        ich_cnt_d = ich_cnt_q + 32'd1;
                        state_d   = S_LD_W3;
                    end else begin
                        ich_cnt_d = '0;
                        state_d   = S_ST_OUT;
                    end
                end
            end
            S_ST_OUT: begin
                if (xfer_done) begin
                    outp_d     = outp_q + out_len;
                    och_base_d = och_base_q + GRP_OCH;
                    if (och_base_d < och_q) begin
                        inp_d   = IN_ADDR;
                        state_d = S_LD_W3;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Launch the request or compute pass belonging to the state being entered
        if (state_d != state_q) begin
            case (state_d)
                S_LD_W3: begin
                    req_valid_d = 1'b1;
                    req_write_d = 1'b0;
                    req_sel_d   = SEL_W3;
                    req_addr_d  = w3p_d;
                    req_len_d   = W3_LEN;
                end
                S_LD_W1: begin
                    req_valid_d = 1'b1;
                    req_write_d = 1'b0;
                    req_sel_d   = SEL_W1;
                    req_addr_d  = w1p_d;
                    req_len_d   = W1_LEN;
                end
                S_LD_IN: begin
                    req_valid_d = 1'b1;
                    req_write_d = 1'b0;
                    req_sel_d   = SEL_IN;
                    req_addr_d  = inp_d;
                    req_len_d   = area_d;
                end
                S_ST_OUT: begin
                    req_valid_d = 1'b1;
                    req_write_d = 1'b1;
                    req_sel_d   = SEL_OUT;
                    req_addr_d  = outp_d;
                    req_len_d   = out_len;
                end
                S_COMP: begin
                    comp_start_d = 1'b1;
                    comp_first_d = (ich_cnt_d == '0);
                    och_left     = och_q - och_base_d;
                    och_num_d    = (och_left >= GRP_OCH) ? MAX_NUM : NW'(och_left);
                end
                default: begin
                end
            endcase
        end

        busy_d   = (state_d != S_IDLE);
        finish_d = (state_q == S_FIN);
    end

    // State, pointer and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            area_q       <= '0;
            ich_q        <= '0;
            och_q        <= '0;
            w3p_q        <= '0;
            w1p_q        <= '0;
            inp_q        <= '0;
            outp_q       <= '0;
            ich_cnt_q    <= '0;
            och_base_q   <= '0;
            req_valid_q  <= 1'b0;
            req_write_q  <= 1'b0;
            req_sel_q    <= '0;
            req_addr_q   <= '0;
            req_len_q    <= '0;
            comp_start_q <= 1'b0;
            comp_first_q <= 1'b0;
            och_num_q    <= '0;
            busy_q       <= 1'b0;
            finish_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            area_q       <= area_d;
            ich_q        <= ich_d;
            och_q        <= och_d;
            w3p_q        <= w3p_d;
            w1p_q        <= w1p_d;
            inp_q        <= inp_d;
            outp_q       <= outp_d;
            ich_cnt_q    <= ich_cnt_d;
            och_base_q   <= och_base_d;
            req_valid_q  <= req_valid_d;
            req_write_q  <= req_write_d;
            req_sel_q    <= req_sel_d;
            req_addr_q   <= req_addr_d;
            req_len_q    <= req_len_d;
            comp_start_q <= comp_start_d;
            comp_first_q <= comp_first_d;
            och_num_q    <= och_num_d;
            busy_q       <= busy_d;
            finish_q     <= finish_d;
        end
    end

    assign bus.dma_req_valid = req_valid_q;
    assign bus.dma_req_write = req_write_q;
    assign bus.dma_req_sel   = req_sel_q;
    assign bus.dma_req_addr  = req_addr_q;
    assign bus.dma_req_len   = req_len_q;
    assign bus.comp_start    = comp_start_q;
    assign bus.comp_first    = comp_first_q;
    assign bus.comp_och_num  = och_num_q;
    assign busy              = busy_q;
    assign conv_finish       = finish_q;
endmodule

// File: tb/tb_conv_main_fsm.sv
// Testbench for conv_main_fsm: DMA/PE responders with random latency, an expected-event
// queue built from the layer parameters, and directed plus random layer runs.
module tb_conv_main_fsm;
    localparam int unsigned PE = 8;

    typedef struct {
        int          kind;   // 0..3 DMA buffer select, 4 compute pass
        logic        wr;
        logic [31:0] addr;
        logic [31:0] len;
        logic        first;
        logic [7:0]  num;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IN_ADDR, W3_ADDR, W1_ADDR, OUT_ADDR, START, MAPSIZE, ICH, OCH;
    logic        busy, conv_finish;
    logic        resp_dma_done, resp_comp_done, stray_dma, stray_comp;

    conv_main_fsm_if bus();

    assign bus.dma_done  = resp_dma_done | stray_dma;
    assign bus.comp_done = resp_comp_done | stray_comp;

    conv_main_fsm #(.PE_OCH(PE)) dut (
        .clk(clk), .rst(rst),
        .IN_ADDR(IN_ADDR), .W3_ADDR(W3_ADDR), .W1_ADDR(W1_ADDR), .OUT_ADDR(OUT_ADDR),
        .START(START), .MAPSIZE(MAPSIZE), .ICH(ICH), .OCH(OCH),
        .bus(bus), .busy(busy), .conv_finish(conv_finish)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   rdy_fixed = -1;
    int   finish_cnt = 0;
    int   req_cnt = 0;
    int   fin_base = 0;
    ev_t  exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void add_ev(int kind, logic wr, logic [31:0] addr, logic [31:0] len,
                                   logic first, logic [7:0] num);
        ev_t e;
        e.kind = kind; e.wr = wr; e.addr = addr; e.len = len; e.first = first; e.num = num;
        exp_q.push_back(e);
    endfunction

    // Expected event order for one layer, straight from the loop-nest description
    task automatic build_expected(input logic [31:0] ms, input logic [31:0] ich_v,
                                  input logic [31:0] och_v);
        logic [31:0] area, w3, w1, inp, outp, left;
        logic [7:0]  num;
        exp_q.delete();
        area = {16'd0, ms[15:0]} * {16'd0, ms[15:0]};
        if (ich_v == 0 || och_v == 0 || area == 0) return;
        w3 = W3_ADDR; w1 = W1_ADDR; outp = OUT_ADDR;
        for (logic [31:0] ob = 0; ob < och_v; ob += 32'(PE)) begin
            inp  = IN_ADDR;
            left = och_v - ob;
            num  = (left > 32'(PE)) ? 8'(PE) : left[7:0];
            for (int i = 0; i < int'(ich_v); i++) begin
                add_ev(0, 1'b0, w3, 32'(9 * PE), 1'b0, 8'd0);  w3 += 32'(9 * PE);
                add_ev(1, 1'b0, w1, 32'(PE), 1'b0, 8'd0);      w1 += 32'(PE);
                add_ev(2, 1'b0, inp, area, 1'b0, 8'd0);        inp += area;
                add_ev(4, 1'b0, 32'd0, 32'd0, (i == 0), num);
            end
            add_ev(3, 1'b1, outp, area * 32'(PE), 1'b0, 8'd0);
            outp += area * 32'(PE);
        end
    endtask

    // DMA responder: ready after a delay, done pulse 0..2 cycles after accept
    initial begin
        int phase, cnt;
        phase = 0; cnt = 0;
        bus.dma_req_ready = 1'b0;
        resp_dma_done = 1'b0;
        forever begin
            @(negedge clk);
            resp_dma_done = 1'b0;
            if (rst) begin
                phase = 0;
                bus.dma_req_ready = 1'b0;
            end else begin
                case (phase)
                    0: if (bus.dma_req_valid) begin
                        cnt = (rdy_fixed >= 0) ? rdy_fixed : int'($urandom_range(0, 3));
                        if (cnt == 0) bus.dma_req_ready = 1'b1;
                        phase = 1;
                    end
                    1: if (bus.dma_req_ready) begin
                        bus.dma_req_ready = 1'b0;
                        cnt = int'($urandom_range(0, 2));
                        if (cnt == 0) begin
                            resp_dma_done = 1'b1;
                            phase = 0;
                        end else begin
                            phase = 2;
                        end
                    end else begin
                        cnt--;
                        if (cnt == 0) bus.dma_req_ready = 1'b1;
                    end
                    default: begin
                        cnt--;
                        if (cnt == 0) begin
                            resp_dma_done = 1'b1;
                            phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    // PE array responder: comp_done 1..4 cycles after comp_start
    initial begin
        int cnt;
        cnt = 0;
        resp_comp_done = 1'b0;
        forever begin
            @(negedge clk);
            resp_comp_done = 1'b0;
            if (rst) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) resp_comp_done = 1'b1;
            end else if (bus.comp_start) begin
                cnt = int'($urandom_range(1, 4));
            end
        end
    end

    // Monitor: request/compute order against the model, request stability while stalled
    initial begin
        logic        prev_valid, prev_write;
        logic [1:0]  prev_sel;
        logic [31:0] prev_addr, prev_len;
        ev_t e;
        prev_valid = 1'b0; prev_write = 1'b0; prev_sel = '0; prev_addr = '0; prev_len = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (prev_valid) begin
                    if (!bus.dma_req_ready) begin
                        chk("hold_valid", 32'(bus.dma_req_valid), 32'd1);
                        chk("hold_addr", bus.dma_req_addr, prev_addr);
                        chk("hold_len", bus.dma_req_len, prev_len);
                        chk("hold_sel", 32'(bus.dma_req_sel), 32'(prev_sel));
                        chk("hold_write", 32'(bus.dma_req_write), 32'(prev_write));
                    end else begin
                        chk("drop_after_accept", 32'(bus.dma_req_valid), 32'd0);
                    end
                end else if (bus.dma_req_valid) begin
                    req_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_req", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("req_sel", 32'(bus.dma_req_sel), 32'(e.kind));
                        chk("req_write", 32'(bus.dma_req_write), 32'(e.wr));
                        chk("req_addr", bus.dma_req_addr, e.addr);
                        chk("req_len", bus.dma_req_len, e.len);
                    end
                end
                if (bus.comp_start) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_comp", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("comp_slot", 32'(e.kind), 32'd4);
                        chk("comp_first", 32'(bus.comp_first), 32'(e.first));
                        chk("comp_och_num", 32'(bus.comp_och_num), 32'(e.num));
                    end
                end
                if (conv_finish) finish_cnt++;
            end
            prev_valid = bus.dma_req_valid;
            prev_write = bus.dma_req_write;
            prev_sel   = bus.dma_req_sel;
            prev_addr  = bus.dma_req_addr;
            prev_len   = bus.dma_req_len;
        end
    end

    task automatic set_regs(input logic [31:0] ms, input logic [31:0] ich_v,
                            input logic [31:0] och_v, input bit new_addr);
        logic [31:0] tmp;
        if (new_addr) begin
            IN_ADDR = $urandom; W3_ADDR = $urandom; W1_ADDR = $urandom; OUT_ADDR = $urandom;
        end
        tmp = $urandom;
        MAPSIZE = {tmp[15:0], ms[15:0]};
        ICH = ich_v;
        OCH = och_v;
        build_expected(ms, ich_v, och_v);
    endtask

    task automatic pulse_start_high();
        logic [31:0] tmp;
        tmp = $urandom;
        START = {tmp[31:1], 1'b1};
    endtask

    task automatic start_layer(input logic [31:0] ms, input logic [31:0] ich_v,
                               input logic [31:0] och_v, input bit new_addr);
        set_regs(ms, ich_v, och_v, new_addr);
        fin_base = finish_cnt;
        @(negedge clk); pulse_start_high();
        @(negedge clk); START = '0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_finish(input int budget);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (conv_finish) begin
                seen = 1'b1;
                break;
            end
        end
        chk("finish_seen", 32'(seen), 32'd1);
        chk("events_left", 32'(exp_q.size()), 32'd0);
        chk("busy_at_finish", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("finish_one_cycle", 32'(conv_finish), 32'd0);
        chk("finish_count", 32'(finish_cnt - fin_base), 32'd1);
    endtask

    task automatic run_layer(input logic [31:0] ms, input logic [31:0] ich_v,
                             input logic [31:0] och_v, input bit new_addr);
        start_layer(ms, ich_v, och_v, new_addr);
        wait_finish(4000);
    endtask

    // Degenerate layer: finish two cycles after START, never a request
    task automatic zero_layer(input logic [31:0] ms, input logic [31:0] ich_v,
                              input logic [31:0] och_v);
        int req_base;
        set_regs(ms, ich_v, och_v, 1'b1);
        req_base = req_cnt;
        @(negedge clk); pulse_start_high();
        @(posedge clk); #1;
        chk("zero_finish_early", 32'(conv_finish), 32'd0);
        chk("zero_busy", 32'(busy), 32'd1);
        @(negedge clk); START = '0;
        @(posedge clk); #1;
        chk("zero_finish", 32'(conv_finish), 32'd1);
        chk("zero_busy_end", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("zero_finish_once", 32'(conv_finish), 32'd0);
        chk("zero_no_req", 32'(req_cnt - req_base), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b1; START = '0; MAPSIZE = '0; ICH = '0; OCH = '0;
        IN_ADDR = '0; W3_ADDR = '0; W1_ADDR = '0; OUT_ADDR = '0;
        stray_dma = 1'b0; stray_comp = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_finish", 32'(conv_finish), 32'd0);
        chk("rst_valid", 32'(bus.dma_req_valid), 32'd0);
        chk("rst_comp_start", 32'(bus.comp_start), 32'd0);
        chk("rst_addr", bus.dma_req_addr, 32'd0);
        chk("rst_len", bus.dma_req_len, 32'd0);
        chk("rst_och_num", 32'(bus.comp_och_num), 32'd0);
        rst = 1'b0;

        // Two input channels, one full group
        run_layer(32'd4, 32'd2, 32'd8, 1'b1);
        // Two groups, partial second group
        run_layer(32'd3, 32'd1, 32'd10, 1'b1);
        // Empty layers
        zero_layer(32'd5, 32'd0, 32'd8);
        zero_layer(32'd0, 32'd2, 32'd8);
        zero_layer(32'd4, 32'd2, 32'd0);

        // Ready withheld five cycles on every request
        rdy_fixed = 5;
        run_layer(32'd2, 32'd1, 32'd8, 1'b1);
        rdy_fixed = -1;

        // START and stray completions while the input-map request is stalled
        rdy_fixed = 6;
        start_layer(32'd3, 32'd1, 32'd8, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            if (bus.dma_req_valid && bus.dma_req_sel == 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        chk("ld_in_seen", 32'(found), 32'd1);
        @(negedge clk);
        pulse_start_high(); stray_dma = 1'b1; stray_comp = 1'b1;
        @(negedge clk);
        START = '0; stray_dma = 1'b0; stray_comp = 1'b0;
        rdy_fixed = -1;
        wait_finish(4000);

        // Reset during a compute pass, then restart with the same bases
        start_layer(32'd3, 32'd2, 32'd16, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #1;
            if (bus.comp_start) begin
                found = 1'b1;
                break;
            end
        end
        chk("comp_seen", 32'(found), 32'd1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(bus.dma_req_valid), 32'd0);
        chk("midrst_comp_start", 32'(bus.comp_start), 32'd0);
        chk("midrst_finish", 32'(conv_finish), 32'd0);
        chk("midrst_addr", bus.dma_req_addr, 32'd0);
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        exp_q.delete();
        run_layer(32'd3, 32'd2, 32'd16, 1'b0);

        // Random layers
        for (int r = 0; r < 6; r++) begin
            logic [31:0] ms, ic, oc;
            ms = 32'($urandom_range(1, 6));
            ic = 32'($urandom_range(1, 3));
            oc = 32'($urandom_range(1, 20));
            run_layer(ms, ic, oc, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
